asip_run_ctrl: RTL
==================

// Module: asip_run_ctrl
// PURPOSE
//  Run/debug controller between the ASIP core and its test/host environment.
//  Sequences core reset and gates execution through a clock enable.
//  Supports free run, single-step, PC breakpoints and a programmable cycle budget.
//  Reports why execution stopped and how many cycles were enabled.
// PARAMETERS
//  PC_W         32  program counter width
//  CYCLE_W      32  cycle counter / budget width
//  NUM_BKPT     2   number of PC breakpoint comparators (>=1)
//  RESET_CYCLES 4   cycles core_rst is held after start (>=1)
// PORTS
//  clk            in   1               single clock, all logic on posedge
//  rst            in   1               synchronous, active-high reset
//  start          in   1               begin run from IDLE/DONE; resume from PAUSE
//  step_mode      in   1               sampled at end of RESET: 1 = enter PAUSE, 0 = RUN
//  step_req       in   1               execute one core cycle while in PAUSE
//  halt_req       in   1               user pause request while in RUN
//  core_halted    in   1               core retired a halt instruction
//  pc             in   PC_W            current core PC
//  bkpt_en        in   NUM_BKPT        per-comparator enable
//  bkpt_addr      in   NUM_BKPT*PC_W   comparator i at [i*PC_W +: PC_W]
//  cfg_max_cycles in   CYCLE_W         enabled-cycle budget; 0 = unlimited
//  core_rst       out  1               reset to core (registered)
//  core_en        out  1               core clock enable (combinational from state + inputs)
//  cycle_cnt      out  CYCLE_W         enabled cycles since last start from IDLE/DONE
//  state_o        out  3               current FSM state
//  stop_cause     out  3               NONE=0 HALT=1 LIMIT=2 BKPT=3 USER=4
//  done           out  1               high while in DONE
// BEHAVIOUR
//  - rst: state IDLE, core_rst=1, cycle_cnt=0, stop_cause=NONE, skip flag=0; core_en=0, done=0.
//  - IDLE: core_rst=1, core_en=0. start -> RESET; clear cycle_cnt and stop_cause.
//  - RESET: core_rst=1 for exactly RESET_CYCLES cycles, counted by rst_cnt.
//    Then -> PAUSE if step_mode else RUN. core_rst falls on entry to RUN/PAUSE.
//  - RUN: core_en = !stop_now. stop_now is taken in priority order:
//    (1) core_halted -> DONE, cause HALT.
//    (2) cfg_max_cycles!=0 && cycle_cnt==cfg_max_cycles -> DONE, cause LIMIT.
//    (3) any bkpt_en[i] && pc==bkpt_addr[i], skip flag clear -> PAUSE, cause BKPT.
//    (4) halt_req -> PAUSE, cause USER.
//    The stopping cycle is not enabled. A breakpoint stops before executing the instruction at pc.
//  - PAUSE: core_en=0.
//    halt_req wins over everything (stay). Otherwise start -> RUN with skip flag set; else step_req -> STEP.
//  - Skip flag: suppresses breakpoint compare for the first RUN cycle only, then clears.
//    This lets a resume move off a breakpoint.
//  - STEP: core_en=1 for exactly one cycle, unless core_halted (-> DONE, cause HALT) or budget exhausted (-> DONE, cause LIMIT).
//    Breakpoints are ignored. Otherwise -> PAUSE with stop_cause unchanged.
//  - DONE: core_en=0, done=1, core_rst=0 (core state kept for inspection). start -> RESET.
//  - cycle_cnt: +1 on every cycle with core_en=1; saturates at all-ones, no wrap.
//  - cfg_max_cycles is sampled live. Lowering it below cycle_cnt never triggers LIMIT; only equality does.
//  - start/step_req in RUN, RESET and STEP: ignored. halt_req outside RUN/PAUSE: ignored.
//  - rst mid-operation overrides every state within the same edge.
// STRUCTURE
//  - asip_run_pkg: state_t enum (IDLE=0, RESET=1, RUN=2, PAUSE=3, STEP=4, DONE=5).
//    Also stop_cause_t enum and the widths of both.
//  - Sub-module asip_bkpt_match: NUM_BKPT comparators -> 1-bit hit. Purely combinational; instanced once.
//  - Top: FSM, rst_cnt (clog2(RESET_CYCLES+1) bits), cycle_cnt, skip flag.
// TESTING
//  1. start, step_mode=0, budget 50, no halt -> core_rst high 4 cycles.
//     Exactly 50 core_en cycles follow, then DONE, cause LIMIT, cycle_cnt=50.
//  2. bkpt_addr[0]=0x10, en=1, pc ramps by 4 -> core_en low when pc=0x10, PAUSE/BKPT.
//     start resumes; the first cycle is enabled despite the match.
//  3. step_mode=1, then 3 step_req pulses -> exactly 3 single enabled cycles, cycle_cnt=3, state PAUSE.
//  4. core_halted and breakpoint hit in the same RUN cycle -> DONE, cause HALT, core_en=0 that cycle.
//  5. halt_req in RUN -> PAUSE/USER next edge. start+halt_req together in PAUSE -> stays PAUSE.
//  6. rst asserted in RUN with cycle_cnt=20 -> next edge IDLE, cycle_cnt=0, core_rst=1, done=0.

Source files
------------

// File: rtl/asip_run_pkg.sv
// Shared types for the ASIP run/debug controller: FSM states, stop causes and their widths.
package asip_run_pkg;

  localparam int STATE_W = 3;
  localparam int CAUSE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_HALT  = 3'd1,
    CAUSE_LIMIT = 3'd2,
    CAUSE_BKPT  = 3'd3,
    CAUSE_USER  = 3'd4
  } stop_cause_t;

endpackage

// File: rtl/asip_bkpt_match.sv
// Bank of PC breakpoint comparators; hit is high when any enabled comparator equals pc.
module asip_bkpt_match #(
  parameter int PC_W     = 32,
  parameter int NUM_BKPT = 2
) (
  input  logic [PC_W-1:0]          pc,
  input  logic [NUM_BKPT-1:0]      bkpt_en,
  input  logic [NUM_BKPT*PC_W-1:0] bkpt_addr,
  output logic                     hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BKPT; i++) begin
      if (bkpt_en[i] && (pc == bkpt_addr[i*PC_W +: PC_W])) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/asip_run_ctrl.sv
// Run/debug controller: sequences core reset, gates the core clock enable for run/step,
// and stops on halt, cycle budget, PC breakpoint or user request, recording the cause.
module asip_run_ctrl
  import asip_run_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int CYCLE_W      = 32,
  parameter int NUM_BKPT     = 2,
  parameter int RESET_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     step_mode,
  input  logic                     step_req,
  input  logic                     halt_req,
  input  logic                     core_halted,
  input  logic [PC_W-1:0]          pc,
  input  logic [NUM_BKPT-1:0]      bkpt_en,
  input  logic [NUM_BKPT*PC_W-1:0] bkpt_addr,
  input  logic [CYCLE_W-1:0]       cfg_max_cycles,
  output logic                     core_rst,
  output logic                     core_en,
  output logic [CYCLE_W-1:0]       cycle_cnt,
  output logic [STATE_W-1:0]       state_o,
  output logic [CAUSE_W-1:0]       stop_cause,
  output logic                     done
);

  localparam int                     RST_CNT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [RST_CNT_W-1:0]   RST_LAST  = RST_CNT_W'(RESET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0]     CNT_MAX   = '1;

  state_t                 state;
  stop_cause_t            cause;
  logic [RST_CNT_W-1:0]   rst_cnt;
  logic                   skip;
  logic                   bkpt_hit;
  logic                   limit_hit;
  logic                   bkpt_stop;

  asip_bkpt_match #(
    .PC_W     (PC_W),
    .NUM_BKPT (NUM_BKPT)
  ) u_bkpt_match (
    .pc        (pc),
    .bkpt_en   (bkpt_en),
    .bkpt_addr (bkpt_addr),
    .hit       (bkpt_hit)
  );

  // Only exact equality ends a run on budget; a budget lowered below the count never fires.
  assign limit_hit = (cfg_max_cycles != '0) && (cycle_cnt == cfg_max_cycles);
  assign bkpt_stop = bkpt_hit && !skip;

  always_comb begin
    core_en = 1'b0;
    case (state)
      S_RUN:   core_en = !(core_halted || limit_hit || bkpt_stop || halt_req);
      S_STEP:  core_en = !(core_halted || limit_hit);
      default: core_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cause     <= CAUSE_NONE;
      core_rst  <= 1'b1;
      cycle_cnt <= '0;
      rst_cnt   <= '0;
      skip      <= 1'b0;
    end else begin
      if (core_en && (cycle_cnt != CNT_MAX)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RESET;
            core_rst  <= 1'b1;
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            cause     <= CAUSE_NONE;
            skip      <= 1'b0;
          end
        end

        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state    <= step_mode ? S_PAUSE : S_RUN;
            core_rst <= 1'b0;
            rst_cnt  <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_RUN: begin
          skip <= 1'b0;
          if (core_halted) begin
            state <= S_DONE;
            cause <= CAUSE_HALT;
          end else if (limit_hit) begin
            state <= S_DONE;
            cause <= CAUSE_LIMIT;
          end else if (bkpt_stop) begin
            state <= S_PAUSE;
            cause <= CAUSE_BKPT;
          end else if (halt_req) begin
            state <= S_PAUSE;
            cause <= CAUSE_USER;
          end
        end

        S_PAUSE: begin
          // A held halt_req pins the controller here even against start.
          if (!halt_req) begin
            if (start) begin
              state <= S_RUN;
              skip  <= 1'b1;
            end else if (step_req) begin
              state <= S_STEP;
            end
          end
        end

        S_STEP: begin
          if (core_halted) begin
            state <= S_DONE;
            cause <= CAUSE_HALT;
          end else if (limit_hit) begin
            state <= S_DONE;
            cause <= CAUSE_LIMIT;
          end else begin
            state <= S_PAUSE;
          end
        end

        default: begin
          state    <= S_IDLE;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

  assign state_o    = state;
  assign stop_cause = cause;
  assign done       = (state == S_DONE);

endmodule
